// File: rtl/alu_mult_sequencer.sv
// Multi-cycle 32x32 low-word multiplier driving the shared ALU.
// Shift-and-add over ADD/SLL/SRL with early exit on a zero multiplier.
module alu_mult_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_shamt_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] prod_q, prod_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

  // Next state, ALU drive and result capture
  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    cnt_d           = cnt_q;
    prod_d          = prod_q;
    alu_operation_o = OP_NOP;
    alu_a_o         = '0;
    alu_b_o         = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = multiplicand_i;
          mplier_d = multiplier_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        if (mplier_q[0]) begin
          alu_operation_o = OP_ADD;
          alu_a_o         = acc_q;
          alu_b_o         = mcand_q;
          acc_d           = alu_data_i;
        end
        state_d = S_SHL;
      end
      S_SHL: begin
        alu_operation_o = OP_SLL;
        alu_b_o         = mcand_q;
        mcand_d         = alu_data_i;
        state_d         = S_SHR;
      end
      S_SHR: begin
        alu_operation_o = OP_SRL;
        alu_b_o         = mplier_q;
        mplier_d        = alu_data_i;
        if (alu_zero_i || (cnt_q == 5'd31)) begin
          prod_d  = acc_q;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = S_ADD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign product_o   = prod_q;
  assign alu_shamt_o = 5'd1;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural ALU.
// Latency, ALU opcode sequence, start filtering and async reset.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [31:0] multiplicand_i;
  logic [31:0] multiplier_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] product_o;
  logic [3:0]  alu_operation_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [4:0]  alu_shamt_o;
  logic [31:0] alu_data_i;
  logic        alu_zero_i;

  int n_asserts = 0;
  int n_fails   = 0;

  alu_mult_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .multiplicand_i  (multiplicand_i),
    .multiplier_i    (multiplier_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .product_o       (product_o),
    .alu_operation_o (alu_operation_o),
    .alu_a_o         (alu_a_o),
    .alu_b_o         (alu_b_o),
    .alu_shamt_o     (alu_shamt_o),
    .alu_data_i      (alu_data_i),
    .alu_zero_i      (alu_zero_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_data_i = 32'h0;
    case (alu_operation_o)
      4'b0011: alu_data_i = alu_a_o + alu_b_o;
      4'b0101: alu_data_i = alu_b_o << alu_shamt_o;
      4'b0110: alu_data_i = alu_b_o >> alu_shamt_o;
      default: alu_data_i = 32'h0;
    endcase
    alu_zero_i = (alu_data_i == 32'h0);
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'b0, done_o}, 32'd0);
    check({tag, "_op"}, {28'b0, alu_operation_o}, 32'd0);
    check({tag, "_a"}, alu_a_o, 32'd0);
    check({tag, "_b"}, alu_b_o, 32'd0);
    check({tag, "_shamt"}, {27'b0, alu_shamt_o}, 32'd1);
  endtask

  // Starts a multiply just after an edge; returns just after E(3k+1).
  task automatic run_mul(input string tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] p,
                         input int k);
    logic [3:0] exp_op;
    multiplicand_i = a;
    multiplier_i   = b;
    start_i        = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3 * k; i++) begin
      case (i % 3)
        0:       exp_op = b[i / 3] ? 4'b0011 : 4'b0000;
        1:       exp_op = 4'b0101;
        default: exp_op = 4'b0110;
      endcase
      check({tag, "_busy"}, {31'b0, busy_o}, 32'd1);
      check({tag, "_done_early"}, {31'b0, done_o}, 32'd0);
      check({tag, "_op"}, {28'b0, alu_operation_o}, {28'b0, exp_op});
      check({tag, "_shamt"}, {27'b0, alu_shamt_o}, 32'd1);
      tick();
    end
    check({tag, "_done"}, {31'b0, done_o}, 32'd1);
    check({tag, "_busy_done"}, {31'b0, busy_o}, 32'd1);
    check({tag, "_product"}, product_o, p);
    check({tag, "_op_done"}, {28'b0, alu_operation_o}, 32'd0);
    tick();
    check_idle_outs({tag, "_after"});
    check({tag, "_product_hold"}, product_o, p);
  endtask

  initial begin
    reset          = 1'b0;
    start_i        = 1'b0;
    multiplicand_i = 32'h0;
    multiplier_i   = 32'h0;
    #2;
    check_idle_outs("rst");
    check("rst_product", product_o, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_mul("m7x5", 32'd7, 32'd5, 32'd35, 3);
    run_mul("mzero", 32'h12345678, 32'd0, 32'd0, 1);
    run_mul("mff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32);
    run_mul("mneg", 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 3);

    // 9x3 with ignored starts at E2 and during DONE
    multiplicand_i = 32'd9;
    multiplier_i   = 32'd3;
    start_i        = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    multiplicand_i = 32'd100;
    multiplier_i   = 32'd100;
    start_i        = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    check("ign_done_e5", {31'b0, done_o}, 32'd0);
    tick();
    check("ign_done_e6", {31'b0, done_o}, 32'd1);
    check("ign_product", product_o, 32'd27);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_idle_outs("ign_e7");
    check("ign_product_hold", product_o, 32'd27);
    run_mul("m100", 32'd100, 32'd100, 32'd10000, 7);

    // Reset in the middle of 0xFFFF x 0xFFFF
    multiplicand_i = 32'h0000FFFF;
    multiplier_i   = 32'h0000FFFF;
    start_i        = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    check("mid_busy", {31'b0, busy_o}, 32'd1);
    @(posedge clk);
    reset = 1'b0;
    #1;
    check_idle_outs("mid_rst");
    check("mid_rst_product", product_o, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_hold_done", {31'b0, done_o}, 32'd0);
      check("mid_rst_hold_busy", {31'b0, busy_o}, 32'd0);
    end
    #2;
    reset = 1'b1;
    tick();
    check_idle_outs("post_rst");
    run_mul("m6x7", 32'd6, 32'd7, 32'd42, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fails);
    $finish;
  end

endmodule
